// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory request/response bundle
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, one-outstanding imem fetcher feeding IF/ID (option: FETCH_MISALIGN_TRAP_EN)
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    instruction_fetch_unit_if.master  bus,
    output logic [31:0]               pc_out,
    output logic [31:0]               instr_out,
    output logic                      instr_valid,
    output logic                      fetch_trap
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t      state, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill, kill_d;
    logic        req_q, req_d;
    logic [31:0] skid_pc, skid_instr;
    logic        skid_load;
    logic        hs;
    logic        occ;
    logic        mis;
    logic        in_trap;
    logic [31:0] tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_q;
    assign mis        = redirect && (redirect_pc[1:0] != 2'b00);
    assign tgt        = redirect_pc;
    assign in_trap    = (state == S_TRAP);
    assign fetch_trap = trap_q;
`else
    // low target bits are dropped: every redirect is forced word aligned
    logic [1:0]  unused_pc_bits;
    assign unused_pc_bits = redirect_pc[1:0];
    assign mis            = 1'b0;
    assign tgt            = {redirect_pc[31:2], 2'b00};
    assign in_trap        = 1'b0;
    assign fetch_trap     = 1'b0;
`endif

    // request is held off while a killed response is still owed by memory
    assign bus.imem_req  = req_q && !kill;
    assign bus.imem_addr = pc_q;
    assign hs            = bus.imem_req && bus.imem_gnt;
    assign occ           = instr_valid && freeze;

    // REQ spends one setup cycle with req low on entry, then requests until granted
    always_comb begin
        state_d   = state;
        pc_d      = pc_q;
        kill_d    = kill;
        req_d     = 1'b0;
        skid_load = 1'b0;
        case (state)
            S_REQ: begin
                if (kill && bus.imem_rvalid) kill_d = 1'b0;
                if (redirect) begin
                    pc_d = tgt;
                    if (hs) kill_d = 1'b1;
                    if (mis)     state_d = state_t'(2'd3);
                    else if (hs) state_d = S_WAIT;
                    else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end
                end else if (hs) begin
                    state_d = S_WAIT;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (kill || redirect) begin
                        kill_d  = 1'b0;
                        if (redirect) pc_d = tgt;
                        state_d = mis ? state_t'(2'd3) : S_REQ;
                    end else if (occ) begin
                        skid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = S_HOLD;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end else if (redirect) begin
                    kill_d  = 1'b1;
                    pc_d    = tgt;
                    state_d = mis ? state_t'(2'd3) : S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = mis ? state_t'(2'd3) : S_REQ;
                end else if (!occ) begin
                    state_d = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                if (kill && bus.imem_rvalid) kill_d = 1'b0;
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = mis ? S_TRAP : S_REQ;
                    req_d   = !mis;
                end
            end
`endif
            default: state_d = S_REQ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_d;
    end

    // PC, kill flag, skid entry and the IF/ID-facing output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            kill        <= 1'b0;
            req_q       <= 1'b0;
            skid_pc     <= 32'h0;
            skid_instr  <= NOP_INSTR;
            pc_out      <= 32'h0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            kill  <= kill_d;
            req_q <= req_d;
            if (skid_load) begin
                skid_pc    <= pc_q;
                skid_instr <= bus.imem_rdata;
            end
            if (redirect) begin
                pc_out      <= mis ? redirect_pc : 32'h0;
                instr_out   <= NOP_INSTR;
                instr_valid <= mis;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_q      <= mis;
`endif
            end else if (in_trap || occ) begin
                pc_out      <= pc_out;
                instr_out   <= instr_out;
                instr_valid <= instr_valid;
            end else if (state == S_WAIT && bus.imem_rvalid && !kill) begin
                pc_out      <= pc_q;
                instr_out   <= bus.imem_rdata;
                instr_valid <= 1'b1;
            end else if (state == S_HOLD) begin
                pc_out      <= skid_pc;
                instr_out   <= skid_instr;
                instr_valid <= 1'b1;
            end else begin
                pc_out      <= 32'h0;
                instr_out   <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out, instr_out, pc_out5, instr_out5;
    logic        instr_valid, fetch_trap, instr_valid5, fetch_trap5;
    int          n_cmp;
    int          n_bad;

    instruction_fetch_unit_if bus();
    instruction_fetch_unit_if bus5();

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus),
        .pc_out(pc_out), .instr_out(instr_out),
        .instr_valid(instr_valid), .fetch_trap(fetch_trap)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut5 (
        .clk(clk), .rst(rst), .freeze(freeze), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus5),
        .pc_out(pc_out5), .instr_out(instr_out5),
        .instr_valid(instr_valid5), .fetch_trap(fetch_trap5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic g, input logic rv, input logic [31:0] rd);
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; freeze = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem(1'b0, 1'b0, 32'h0);
        bus5.imem_gnt = 1'b0; bus5.imem_rvalid = 1'b0; bus5.imem_rdata = 32'h0;
        tick(); tick();
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_pc",    pc_out, 32'h0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_trap",  {31'h0, fetch_trap}, 32'h0);
        chk("rst_addr5", bus5.imem_addr, 32'hFFFF_FFFC);

        // test 1: sequential fetch, gnt with req, rvalid one cycle later
        rst = 1'b0;
        chk("t1_req_c0", {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk("t1_req_c1",  {31'h0, bus.imem_req}, 32'h1);
        chk("t1_addr0",   bus.imem_addr, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        chk("t1_req_wait", {31'h0, bus.imem_req}, 32'h0);
        mem(1'b0, 1'b1, 32'h0050_0093);
        tick();
        chk("t1_valid0", {31'h0, instr_valid}, 32'h1);
        chk("t1_pc0",    pc_out, 32'h0);
        chk("t1_instr0", instr_out, 32'h0050_0093);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        chk("t1_bubble", {31'h0, instr_valid}, 32'h0);
        chk("t1_req4",   {31'h0, bus.imem_req}, 32'h1);
        chk("t1_addr4",  bus.imem_addr, 32'h4);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'h00a0_0113);
        tick();
        chk("t1_pc4",    pc_out, 32'h4);
        chk("t1_valid4", {31'h0, instr_valid}, 32'h1);

        // test 2: freeze for 4 cycles while pc 4 is valid; next word goes to skid
        mem(1'b0, 1'b0, 32'h0);
        freeze = 1'b1;
        tick();
        chk("t2_hold1", pc_out, 32'h4);
        chk("t2_addr8", bus.imem_addr, 32'h8);
        chk("t2_req8",  {31'h0, bus.imem_req}, 32'h1);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        chk("t2_hold2", pc_out, 32'h4);
        mem(1'b0, 1'b1, 32'h00f0_0193);
        tick();
        chk("t2_hold3",  pc_out, 32'h4);
        chk("t2_instr3", instr_out, 32'h00a0_0113);
        chk("t2_reqhold", {31'h0, bus.imem_req}, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        chk("t2_hold4",  pc_out, 32'h4);
        chk("t2_valid4", {31'h0, instr_valid}, 32'h1);
        freeze = 1'b0;
        tick();
        chk("t2_pc8",    pc_out, 32'h8);
        chk("t2_instr8", instr_out, 32'h00f0_0193);
        chk("t2_valid8", {31'h0, instr_valid}, 32'h1);
        tick();
        chk("t2_nodup",  {31'h0, instr_valid}, 32'h0);
        chk("t2_addr12", bus.imem_addr, 32'hC);

        // test 3: redirect while waiting, stale rvalid two cycles later
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("t3_req_wait", {31'h0, bus.imem_req}, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        chk("t3_dropped", {31'h0, instr_valid}, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        chk("t3_req100",  {31'h0, bus.imem_req}, 32'h1);
        chk("t3_addr100", bus.imem_addr, 32'h100);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'h1111_1111);
        tick();
        chk("t3_pc100",    pc_out, 32'h100);
        chk("t3_instr100", instr_out, 32'h1111_1111);
        mem(1'b0, 1'b0, 32'h0);

        // test 4: redirect in the same cycle as the grant
        tick();
        chk("t4_addr104", bus.imem_addr, 32'h104);
        mem(1'b1, 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        mem(1'b0, 1'b1, 32'hBADB_AD00);
        chk("t4_bubble1", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("t4_bubble2", {31'h0, instr_valid}, 32'h0);
        chk("t4_addr200", bus.imem_addr, 32'h200);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        chk("t4_req200", {31'h0, bus.imem_req}, 32'h1);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'h2222_2222);
        tick();
        chk("t4_pc200",    pc_out, 32'h200);
        chk("t4_instr200", instr_out, 32'h2222_2222);
        // unsolicited rvalid while nothing is outstanding
        mem(1'b0, 1'b1, 32'h5555_5555);
        tick();
        chk("t4_unsolicited", {31'h0, instr_valid}, 32'h0);
        chk("t4_addr204",     bus.imem_addr, 32'h204);

        // tests 6/7: misaligned redirect to 0x102
        mem(1'b0, 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_trap",  {31'h0, fetch_trap}, 32'h1);
        chk("t6_pc",    pc_out, 32'h102);
        chk("t6_instr", instr_out, NOP);
        chk("t6_valid", {31'h0, instr_valid}, 32'h1);
        chk("t6_req",   {31'h0, bus.imem_req}, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        chk("t6_trap_hold", {31'h0, fetch_trap}, 32'h1);
        chk("t6_req_hold",  {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk("t6_pc_hold", pc_out, 32'h102);
        mem(1'b0, 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("t6_trap_clr", {31'h0, fetch_trap}, 32'h0);
        chk("t6_exit_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t6_exit_addr", bus.imem_addr, 32'h200);
`else
        chk("t7_addr", bus.imem_addr, 32'h100);
        chk("t7_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("t7_trap", {31'h0, fetch_trap}, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'h3333_3333);
        tick();
        chk("t7_pc",    pc_out, 32'h100);
        chk("t7_instr", instr_out, 32'h3333_3333);
        chk("t7_trap2", {31'h0, fetch_trap}, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
`endif

        // test 5: reset mid-operation, RESET_PC wrap on the second instance
        rst = 1'b1;
        tick(); tick();
        chk("t5_rst_addr5", bus5.imem_addr, 32'hFFFF_FFFC);
        chk("t5_rst_valid", {31'h0, instr_valid}, 32'h0);
        rst = 1'b0;
        mem(1'b0, 1'b1, 32'h7777_7777);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("t5_stale_ignored", {31'h0, instr_valid}, 32'h0);
        chk("t5_main_addr",     bus.imem_addr, 32'h0);
        chk("t5_req5",  {31'h0, bus5.imem_req}, 32'h1);
        chk("t5_addr5", bus5.imem_addr, 32'hFFFF_FFFC);
        bus5.imem_gnt = 1'b1;
        tick();
        bus5.imem_gnt = 1'b0; bus5.imem_rvalid = 1'b1; bus5.imem_rdata = 32'h4444_4444;
        tick();
        bus5.imem_rvalid = 1'b0;
        chk("t5_pc5",    pc_out5, 32'hFFFF_FFFC);
        chk("t5_valid5", {31'h0, instr_valid5}, 32'h1);
        tick();
        chk("t5_wrap_req",  {31'h0, bus5.imem_req}, 32'h1);
        chk("t5_wrap_addr", bus5.imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
